// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the programmable pulse generator.
// Optional sync_out port is enabled with PULSE_GEN_SYNC_OUT_EN (see pulse_gen_if/pulse_gen).
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A pulse_count of this value makes the burst run until stop or reset.
  localparam int CONTINUOUS = 0;

endpackage

// File: rtl/pulse_gen_if.sv
// Control/status bundle for pulse_gen; master drives config, slave is the generator.
// sync_out exists only when PULSE_GEN_SYNC_OUT_EN is defined.
interface pulse_gen_if #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 8
) ();

  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  high_len;
  logic [CNT_W-1:0]  low_len;
  logic [PCNT_W-1:0] pulse_count;
  logic              signal;
  logic              busy;
  logic              done;
  logic [PCNT_W-1:0] pulses_done;

`ifdef PULSE_GEN_SYNC_OUT_EN
  logic              sync_out;

  modport master (
    output start, stop, high_len, low_len, pulse_count,
    input  signal, busy, done, pulses_done, sync_out
  );

  modport slave (
    input  start, stop, high_len, low_len, pulse_count,
    output signal, busy, done, pulses_done, sync_out
  );
`else
  modport master (
    output start, stop, high_len, low_len, pulse_count,
    input  signal, busy, done, pulses_done
  );

  modport slave (
    input  start, stop, high_len, low_len, pulse_count,
    output signal, busy, done, pulses_done
  );
`endif

endinterface

// File: rtl/pulse_gen_phase_counter.sv
// Phase counter for pulse_gen: loads to 1, counts up, flags when it equals the limit.
module phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= CNT_W'(1);
    else if (inc)
      count <= count + CNT_W'(1);
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/pulse_gen.sv
// Programmable burst pulse generator: run-time high/low lengths and pulse count, 0 = continuous.
// Define PULSE_GEN_SYNC_OUT_EN to add the registered sync_out rising-edge strobe.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 8
) (
  input  logic     clock,
  input  logic     reset,
  pulse_gen_if.slave bus
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  hi_q, lo_q, limit;
  logic [PCNT_W-1:0] count_q, pd_q, pd_next;
  logic              signal_q, signal_next;
  logic              busy_q, busy_next;
  logic              done_q, done_next;
  logic              latch, cnt_load, cnt_inc, at_limit, more_pulses;

  // One counter serves both phases; the limit follows the current phase.
  assign limit       = (state == LOW) ? lo_q : hi_q;
  assign more_pulses = (count_q == PCNT_W'(CONTINUOUS)) || (pd_q < count_q);

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .limit    (limit),
    .at_limit (at_limit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pd_q     <= '0;
      hi_q     <= CNT_W'(1);
      lo_q     <= CNT_W'(1);
      count_q  <= '0;
    end else begin
      state    <= state_next;
      signal_q <= signal_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
      pd_q     <= pd_next;
      if (latch) begin
        hi_q    <= (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
        lo_q    <= (bus.low_len  == '0) ? CNT_W'(1) : bus.low_len;
        count_q <= bus.pulse_count;
      end
    end
  end

  // stop overrides every transition; outputs default to the idle values.
  always_comb begin
    state_next  = state;
    pd_next     = pd_q;
    signal_next = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    latch       = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    if (bus.stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_next  = HIGH;
            latch       = 1'b1;
            cnt_load    = 1'b1;
            pd_next     = PCNT_W'(1);
            signal_next = 1'b1;
            busy_next   = 1'b1;
          end
        end
        HIGH: begin
          busy_next = 1'b1;
          if (at_limit) begin
            state_next = LOW;
            cnt_load   = 1'b1;
          end else begin
            signal_next = 1'b1;
            cnt_inc     = 1'b1;
          end
        end
        LOW: begin
          if (!at_limit) begin
            busy_next = 1'b1;
            cnt_inc   = 1'b1;
          end else if (more_pulses) begin
            state_next  = HIGH;
            cnt_load    = 1'b1;
            signal_next = 1'b1;
            busy_next   = 1'b1;
            pd_next     = pd_q + PCNT_W'(1);
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.signal      = signal_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_done = pd_q;

`ifdef PULSE_GEN_SYNC_OUT_EN
  logic sync_q;

  // Entering HIGH from any other state is exactly a 0->1 edge of signal.
  always_ff @(posedge clock) begin
    if (reset)
      sync_q <= 1'b0;
    else
      sync_q <= (state_next == HIGH) && (state != HIGH);
  end

  assign bus.sync_out = sync_q;
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: burst table, hand-written corner cases, random run vs model.
// Also checks sync_out when built with PULSE_GEN_SYNC_OUT_EN.
module tb_pulse_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  pulse_gen_if #(.CNT_W(8), .PCNT_W(8)) pg ();

  pulse_gen #(.CNT_W(8), .PCNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (pg)
  );

  // Reference model: position t inside the burst determines every output arithmetically.
  int m_phase = 0;  // 0 idle, 1 active, 2 done
  int m_t = 0, m_hi = 1, m_lo = 1, m_cnt = 0, m_pd = 0;

  task automatic model_step();
    int p;
    if (reset) begin
      m_phase = 0;
      m_pd    = 0;
    end else if (pg.stop) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (pg.start) begin
          m_phase = 1;
          m_t     = 0;
          m_hi    = (pg.high_len == 8'd0) ? 1 : int'(pg.high_len);
          m_lo    = (pg.low_len  == 8'd0) ? 1 : int'(pg.low_len);
          m_cnt   = int'(pg.pulse_count);
          m_pd    = 1;
        end
        1: begin
          p   = m_hi + m_lo;
          m_t = m_t + 1;
          if (m_cnt != 0 && m_t == m_cnt * p) m_phase = 2;
          else m_pd = (m_t / p + 1) % 256;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_model();
    int p;
    p = m_hi + m_lo;
    checkOutput("signal", int'(pg.signal), int'(m_phase == 1 && (m_t % p) < m_hi));
    checkOutput("busy", int'(pg.busy), int'(m_phase == 1));
    checkOutput("done", int'(pg.done), int'(m_phase == 2));
    checkOutput("pulses_done", int'(pg.pulses_done), m_pd);
`ifdef PULSE_GEN_SYNC_OUT_EN
    checkOutput("sync_out", int'(pg.sync_out), int'(m_phase == 1 && (m_t % p) == 0));
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic sp,
                               input int hl, input int ll, input int pc);
    reset          = rst;
    pg.start       = st;
    pg.stop        = sp;
    pg.high_len    = 8'(hl);
    pg.low_len     = 8'(ll);
    pg.pulse_count = 8'(pc);
  endtask

  // Counts cycles from the current (first high) cycle until the done strobe appears.
  task automatic run_until_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (pg.done) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL timeout: got no done after %0d cycles expected done", budget);
    cyc = -1;
  endtask

  typedef struct {
    int hl;
    int ll;
    int pc;
    int exp_cycles;
    int exp_pd;
  } burst_vec_t;

  burst_vec_t vecs[5];

  initial begin
    int cyc;
    logic [19:0] pat;

    vecs[0] = '{hl: 3, ll: 2, pc: 4, exp_cycles: 20, exp_pd: 4};
    vecs[1] = '{hl: 0, ll: 0, pc: 3, exp_cycles: 6,  exp_pd: 3};
    vecs[2] = '{hl: 2, ll: 3, pc: 2, exp_cycles: 10, exp_pd: 2};
    vecs[3] = '{hl: 1, ll: 5, pc: 1, exp_cycles: 6,  exp_pd: 1};
    vecs[4] = '{hl: 7, ll: 0, pc: 3, exp_cycles: 24, exp_pd: 3};

    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_signal", int'(pg.signal), 0);
    checkOutput("rst_busy", int'(pg.busy), 0);
    checkOutput("rst_done", int'(pg.done), 0);
    checkOutput("rst_pulses_done", int'(pg.pulses_done), 0);

    // Counted burst 3/2 x4: exact waveform, then done strobe.
    pat = 20'b11100_11100_11100_11100;
    applyStimulus(0, 1, 0, 3, 2, 4);
    tick();
    applyStimulus(0, 0, 0, 3, 2, 4);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      checkOutput("pattern", int'(pg.signal), int'(pat[19-i]));
    end
    tick();
    checkOutput("burst_done", int'(pg.done), 1);
    checkOutput("burst_busy", int'(pg.busy), 0);
    checkOutput("burst_pd", int'(pg.pulses_done), 4);
    tick();
    checkOutput("done_one_cycle", int'(pg.done), 0);
    checkOutput("pd_held", int'(pg.pulses_done), 4);

    foreach (vecs[v]) begin
      applyStimulus(0, 1, 0, vecs[v].hl, vecs[v].ll, vecs[v].pc);
      tick();
      applyStimulus(0, 0, 0, 9, 9, 9);
      run_until_done(2000, cyc);
      checkOutput("table_len", cyc, vecs[v].exp_cycles);
      checkOutput("table_pd", int'(pg.pulses_done), vecs[v].exp_pd);
      tick();
    end

    // Continuous 4/4, stop in cycle 2 of pulse 5 (t = 33).
    applyStimulus(0, 1, 0, 4, 4, 0);
    tick();
    applyStimulus(0, 0, 0, 4, 4, 0);
    repeat (33) tick();
    applyStimulus(0, 0, 1, 4, 4, 0);
    tick();
    checkOutput("stop_signal", int'(pg.signal), 0);
    checkOutput("stop_busy", int'(pg.busy), 0);
    checkOutput("stop_done", int'(pg.done), 0);
    checkOutput("stop_pd", int'(pg.pulses_done), 5);
    applyStimulus(0, 0, 0, 4, 4, 0);
    repeat (3) tick();

    // Reset in the middle of a burst.
    applyStimulus(0, 1, 0, 3, 3, 5);
    tick();
    applyStimulus(0, 0, 0, 3, 3, 5);
    repeat (4) tick();
    applyStimulus(1, 0, 0, 3, 3, 5);
    tick();
    checkOutput("midrst_signal", int'(pg.signal), 0);
    checkOutput("midrst_busy", int'(pg.busy), 0);
    checkOutput("midrst_pd", int'(pg.pulses_done), 0);
    applyStimulus(0, 0, 0, 3, 3, 5);
    tick();

    // start together with stop in IDLE.
    applyStimulus(0, 1, 1, 2, 2, 2);
    tick();
    tick();
    checkOutput("startstop_busy", int'(pg.busy), 0);
    checkOutput("startstop_signal", int'(pg.signal), 0);

    // start toggling and config changes during a burst are ignored.
    applyStimulus(0, 1, 0, 2, 2, 3);
    tick();
    cyc = 0;
    while (cyc < 200) begin
      applyStimulus(0, cyc[0], 0, cyc % 5, 7, 1);
      tick();
      cyc++;
      if (pg.done) break;
    end
    checkOutput("ignore_start_len", cyc, 12);
    applyStimulus(0, 0, 0, 2, 2, 3);
    tick();

    // Start held through DONE: exactly one idle cycle before the next burst.
    applyStimulus(0, 1, 0, 1, 1, 1);
    tick();
    tick();
    tick();
    checkOutput("retrig_done", int'(pg.done), 1);
    tick();
    checkOutput("retrig_idle", int'(pg.busy), 0);
    tick();
    checkOutput("retrig_busy", int'(pg.busy), 1);
    checkOutput("retrig_signal", int'(pg.signal), 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    run_until_done(100, cyc);
    tick();

    // Continuous 1/1 for 257 pulses: pulses_done wraps to 1.
    applyStimulus(0, 1, 0, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0);
    repeat (512) tick();
    checkOutput("wrap_pd", int'(pg.pulses_done), 1);
    checkOutput("wrap_signal", int'(pg.signal), 1);
    applyStimulus(0, 0, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0);
    tick();

`ifdef PULSE_GEN_SYNC_OUT_EN
    applyStimulus(0, 1, 0, 2, 3, 2);
    tick();
    applyStimulus(0, 0, 0, 2, 3, 2);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      checkOutput("sync_pattern", int'(pg.sync_out), int'(i == 0 || i == 5));
    end
    tick();
    tick();
`endif

    // Random traffic against the model, including config churn mid-burst.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 59) == 0, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
